prf_rw_sb: RTL and testbench
============================

# prf_rw_sb

Parametrised physical register file: WIDTH-bit entries, DEPTH entries, one write port, two registered read ports and one allocate port. It has a per-entry ready (scoreboard) bit and a pending-entry counter. It is the next-generation register file for the lab datapath, feeding operand-ready information to issue logic alongside operand data. It adds write-to-read bypass, optional hardwired-zero entry 0 and clean asynchronous reset.

## Interface
- WIDTH, 64, entry data width in bits
- DEPTH, 32, number of entries (need not be a power of two, min 2)
- AW, 5, address width; must satisfy 2^AW >= DEPTH
- ZERO_REG, 1, when 1 entry 0 reads as zero, is always ready and ignores writes and allocates
- clk  input  1  clock, all state changes on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- EN  input  1  global enable; when 0, no state changes and outputs hold
- WR  input  1  write strobe
- si1  input  AW  write address
- I1  input  WIDTH  write data
- RD  input  1  read strobe for both read ports
- so1, so2  input  AW  read addresses
- AL  input  1  allocate strobe (marks entry not-ready)
- sa  input  AW  allocate address
- O1, O2  output  WIDTH  registered read data
- V1, V2  output  1  registered ready bit of the entry read
- RV  output  1  read-valid; high for one cycle after an accepted read
- pend_cnt  output  AW+1  number of entries currently not ready

## Operation
- State: data array [DEPTH] x WIDTH, ready[DEPTH], pend_cnt, output registers.
- An address is legal when it is < DEPTH. When ZERO_REG=1, address 0 is excluded for writes and allocates.
- Write (EN & WR & legal si1): data[si1] <= I1, ready[si1] <= 1.
- Allocate (EN & AL & legal sa): ready[sa] <= 0. Data is unchanged.
- Write and allocate to the same address in one cycle: data is written and ready ends at 0 (allocate wins).
- Read (EN & RD): for each port, O gets the next-state data and V gets the next-state ready of the addressed entry.
  - Same-cycle write to so1/so2 is bypassed: O = I1.
  - V = 1 unless the same entry is also allocated that cycle.
- Illegal read address: O = 0, V = 0. With ZERO_REG=1 and address 0: O = 0, V = 1.
- RV <= EN & RD. When there is no accepted read, O1/O2/V1/V2 hold their values and RV <= 0.
- pend_cnt counts entries whose ready bit actually changes:
  - +1 for each 1->0 transition (allocate of a ready entry)
  - -1 for each 1 transition of a not-ready entry back to ready (write without same-address allocate)
  - Write and allocate of different entries in one cycle: both effects apply (net 0 if both transition).
  - Allocate of an already-pending entry and write of an already-ready entry: no change.
- Illegal write or allocate: ignored, no counter change.
- EN = 0: the data array, ready bits, pend_cnt, O/V hold. RV is forced to 0 at the next edge.

## Timing
- Reset (rst = 0, asynchronous, immediate): all data = 0, all ready = 1, pend_cnt = 0, O1 = O2 = 0, V1 = V2 = 0, RV = 0.
- Reset deassertion is taken synchronously. First state change is at the first rising edge with rst = 1.
- Reset asserted mid-operation: any in-flight write or allocate is lost; state is exactly the reset state.
- Read latency: 1 cycle. Address is presented in cycle N; O/V/RV are valid after edge N+1 and remain until the next accepted read.
- Write-to-read: 0-cycle bypass (write and read of the same address in the same cycle return the new data).
- Write then allocate ordering is by cycle. A later-cycle allocate clears ready set by an earlier write.
- pend_cnt range 0..DEPTH (less 1 if ZERO_REG). It cannot wrap by construction; the verifier checks it equals the popcount of ~ready every cycle.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold rst = 0, then release. All O = 0, V = 0, RV = 0, pend_cnt = 0; read of entries 5 and 31 then gives O = 0, V = 1.
- Write/read: write 64'hDEADBEEF_01234567 to entry 7 in cycle 1, RD so1 = 7 in cycle 3 -> O1 = 64'hDEADBEEF_01234567, V1 = 1, RV = 1 for exactly one cycle.
- Bypass: WR si1 = 9, I1 = 64'hA5, plus RD so1 = 9 and so2 = 9 in the same cycle -> next cycle O1 = O2 = 64'hA5, V1 = V2 = 1.
- Scoreboard: AL sa = 4 -> pend_cnt = 1, read 4 gives V = 0. Write 4 with 64'h11 -> pend_cnt = 0, V = 1. Same-cycle AL and WR to 4 -> pend_cnt = 1, V = 0, data = new value.
- Zero register and illegal address: with ZERO_REG = 1, write 64'hFF to 0 and AL sa = 0 -> read 0 gives O = 0, V = 1, pend_cnt unchanged. With DEPTH = 20, read address 25 -> O = 0, V = 0.
- Enable and async reset: EN = 0 with WR/AL/RD active -> no state change and RV = 0. Assert rst = 0 mid-cycle after three allocates -> pend_cnt = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/prf_rw_sb.sv
// Physical register file with per-entry ready scoreboard, pending counter,
// write-to-read bypass and optional hardwired-zero entry 0.
module prf_rw_sb #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic             WR,
    input  logic [AW-1:0]    si1,
    input  logic [WIDTH-1:0] I1,
    input  logic             RD,
    input  logic [AW-1:0]    so1,
    input  logic [AW-1:0]    so2,
    input  logic             AL,
    input  logic [AW-1:0]    sa,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic             V1,
    output logic             V2,
    output logic             RV,
    output logic [AW:0]      pend_cnt
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] ready;

    logic             wr_ok;
    logic             al_ok;
    logic             pend_inc;
    logic             pend_dec;
    logic [AW-1:0]    ra  [2];
    logic [WIDTH-1:0] rdo [2];
    logic             rdv [2];

    assign ra[0] = so1;
    assign ra[1] = so2;

    always_comb begin
        wr_ok    = EN && WR && in_range(si1) && !is_zero(si1);
        al_ok    = EN && AL && in_range(sa)  && !is_zero(sa);
        pend_inc = al_ok && ready[sa];
        // A write only releases an entry if no same-address allocate re-claims it.
        pend_dec = wr_ok && !ready[si1] && !(al_ok && (sa == si1));
        for (int unsigned p = 0; p < 2; p++) begin
            rdo[p] = '0;
            rdv[p] = 1'b0;
            if (in_range(ra[p])) begin
                if (is_zero(ra[p])) begin
                    rdv[p] = 1'b1;
                end else if (wr_ok && (si1 == ra[p])) begin
                    rdo[p] = I1;
                    rdv[p] = 1'b1;
                end else begin
                    rdo[p] = mem[ra[p]];
                    rdv[p] = ready[ra[p]];
                end
                if (al_ok && (sa == ra[p])) rdv[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            ready    <= '1;
            pend_cnt <= '0;
            O1       <= '0;
            O2       <= '0;
            V1       <= 1'b0;
            V2       <= 1'b0;
            RV       <= 1'b0;
        end else begin
            RV <= EN && RD;
            if (wr_ok) begin
                mem[si1]   <= I1;
                ready[si1] <= 1'b1;
            end
            if (al_ok) ready[sa] <= 1'b0;
            pend_cnt <= pend_cnt + {{AW{1'b0}}, pend_inc} - {{AW{1'b0}}, pend_dec};
            if (EN && RD) begin
                O1 <= rdo[0];
                O2 <= rdo[1];
                V1 <= rdv[0];
                V2 <= rdv[1];
            end
        end
    end

endmodule

// File: tb/tb_prf_rw_sb.sv
// Scoreboard bench for prf_rw_sb: a DEPTH=32 and a DEPTH=20 instance share stimulus,
// each checked against an array-based reference model through expectation queues.
module tb_prf_rw_sb;

    localparam int W  = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          EN  = 1'b0;
    logic          WR  = 1'b0;
    logic          RD  = 1'b0;
    logic          AL  = 1'b0;
    logic [AW-1:0] si1 = '0;
    logic [AW-1:0] so1 = '0;
    logic [AW-1:0] so2 = '0;
    logic [AW-1:0] sa  = '0;
    logic [W-1:0]  I1  = '0;

    logic [W-1:0]  o1 [2];
    logic [W-1:0]  o2 [2];
    logic          v1 [2];
    logic          v2 [2];
    logic          rv [2];
    logic [AW:0]   pc [2];

    prf_rw_sb #(.WIDTH(W), .DEPTH(32), .AW(AW), .ZERO_REG(1)) u_d32 (
        .clk(clk), .rst(rst), .EN(EN), .WR(WR), .si1(si1), .I1(I1), .RD(RD),
        .so1(so1), .so2(so2), .AL(AL), .sa(sa), .O1(o1[0]), .O2(o2[0]),
        .V1(v1[0]), .V2(v2[0]), .RV(rv[0]), .pend_cnt(pc[0])
    );

    prf_rw_sb #(.WIDTH(W), .DEPTH(20), .AW(AW), .ZERO_REG(1)) u_d20 (
        .clk(clk), .rst(rst), .EN(EN), .WR(WR), .si1(si1), .I1(I1), .RD(RD),
        .so1(so1), .so2(so2), .AL(AL), .sa(sa), .O1(o1[1]), .O2(o2[1]),
        .V1(v1[1]), .V2(v2[1]), .RV(rv[1]), .pend_cnt(pc[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] o1;
        logic [W-1:0] o2;
        logic         v1;
        logic         v2;
    } rd_t;

    typedef struct {
        logic        rv;
        logic [AW:0] pend;
    } cyc_t;

    rd_t          rd_q  [2][$];
    cyc_t         cyc_q [2][$];
    rd_t          last  [2];
    logic [W-1:0] md    [2][32];
    bit           mr    [2][32];

    int n_vec = 0;
    int n_err = 0;

    function automatic int depth_of(input int k);
        return (k == 0) ? 32 : 20;
    endfunction

    task automatic chk(input string nm, input int k, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[d%0d] @%0t: got %h expected %h", nm, depth_of(k), $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) begin
                md[k][i] = '0;
                mr[k][i] = 1'b1;
            end
            last[k] = '{o1: '0, o2: '0, v1: 1'b0, v2: 1'b0};
            rd_q[k].delete();
            cyc_q[k].delete();
        end
    endtask

    // Reference: build the next-state arrays from the rules, then read them.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int           dep;
            logic [W-1:0] nd [32];
            bit           nr [32];
            bit           wl, al;
            cyc_t         c;
            rd_t          r;
            dep = depth_of(k);
            for (int i = 0; i < 32; i++) begin
                nd[i] = md[k][i];
                nr[i] = mr[k][i];
            end
            wl = EN && WR && (int'(si1) < dep) && (si1 != 0);
            al = EN && AL && (int'(sa) < dep) && (sa != 0);
            if (wl) begin
                nd[si1] = I1;
                nr[si1] = 1'b1;
            end
            if (al) nr[sa] = 1'b0;
            c.rv = EN && RD;
            if (c.rv) begin
                r.o1 = (int'(so1) < dep) ? nd[so1] : '0;
                r.v1 = (int'(so1) < dep) ? nr[so1] : 1'b0;
                r.o2 = (int'(so2) < dep) ? nd[so2] : '0;
                r.v2 = (int'(so2) < dep) ? nr[so2] : 1'b0;
                rd_q[k].push_back(r);
            end
            c.pend = '0;
            for (int i = 0; i < dep; i++) if (!nr[i]) c.pend++;
            cyc_q[k].push_back(c);
            for (int i = 0; i < 32; i++) begin
                md[k][i] = nd[i];
                mr[k][i] = nr[i];
            end
        end
    endtask

    task automatic drive(input bit en, input bit wr, input int wa, input logic [W-1:0] wd,
                         input bit rd, input int r1, input int r2, input bit al, input int aa);
        @(negedge clk);
        EN  = en;
        WR  = wr;
        si1 = AW'(wa);
        I1  = wd;
        RD  = rd;
        so1 = AW'(r1);
        so2 = AW'(r2);
        AL  = al;
        sa  = AW'(aa);
        model_step();
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        EN = 0; WR = 0; RD = 0; AL = 0;
        rst = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("rst_pend", k, W'(pc[k]), '0);
            chk("rst_o1",   k, o1[k], '0);
            chk("rst_o2",   k, o2[k], '0);
            chk("rst_v",    k, W'({v1[k], v2[k]}), '0);
            chk("rst_rv",   k, W'(rv[k]), '0);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic rand_cycles(input int n);
        for (int t = 0; t < n; t++) begin
            int a0, a1, a2, a3;
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            a0 = narrow ? $urandom_range(0, 7) : $urandom_range(0, 31);
            a1 = narrow ? $urandom_range(0, 7) : $urandom_range(0, 31);
            a2 = narrow ? $urandom_range(0, 7) : $urandom_range(0, 31);
            a3 = narrow ? $urandom_range(0, 7) : $urandom_range(0, 31);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, a0, {$urandom, $urandom},
                  $urandom_range(0, 9) < 6, a1, a2, $urandom_range(0, 9) < 3, a3);
        end
    endtask

    // Monitor: one expectation per driven cycle; read data popped whenever a read was accepted.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (cyc_q[k].size() > 0) begin
                    cyc_t c;
                    c = cyc_q[k].pop_front();
                    chk("rv",   k, W'(rv[k]), W'(c.rv));
                    chk("pend", k, W'(pc[k]), W'(c.pend));
                    if (c.rv) begin
                        if (rd_q[k].size() > 0) begin
                            last[k] = rd_q[k].pop_front();
                        end else begin
                            n_vec++;
                            n_err++;
                            $display("FAIL rdq[d%0d]: got empty queue expected read entry", depth_of(k));
                        end
                    end
                    chk("o1", k, o1[k], last[k].o1);
                    chk("o2", k, o2[k], last[k].o2);
                    chk("v1", k, W'(v1[k]), W'(last[k].v1));
                    chk("v2", k, W'(v2[k]), W'(last[k].v2));
                end
            end
        end
    end

    initial begin
        model_reset();
        do_reset();
        idle();
        drive(1, 0, 0, '0, 1, 5, 31, 0, 0);
        idle();
        drive(1, 1, 7, 64'hDEADBEEF_01234567, 0, 0, 0, 0, 0);
        idle();
        drive(1, 0, 0, '0, 1, 7, 7, 0, 0);
        idle();
        idle();
        drive(1, 1, 9, 64'hA5, 1, 9, 9, 0, 0);
        idle();
        drive(1, 0, 0, '0, 0, 0, 0, 1, 4);
        drive(1, 0, 0, '0, 1, 4, 4, 0, 0);
        drive(1, 1, 4, 64'h11, 0, 0, 0, 0, 0);
        drive(1, 0, 0, '0, 1, 4, 7, 0, 0);
        drive(1, 1, 4, 64'h22, 1, 4, 9, 1, 4);
        drive(1, 0, 0, '0, 1, 4, 4, 0, 0);
        drive(1, 1, 0, 64'hFF, 0, 0, 0, 1, 0);
        drive(1, 0, 0, '0, 1, 0, 0, 0, 0);
        drive(1, 1, 25, 64'h77, 1, 25, 19, 1, 22);
        drive(1, 0, 0, '0, 1, 25, 22, 0, 0);
        drive(0, 1, 3, 64'h33, 1, 3, 4, 1, 5);
        drive(1, 0, 0, '0, 1, 3, 5, 0, 0);
        idle();
        rand_cycles(600);
        drive(1, 0, 0, '0, 0, 0, 0, 1, 1);
        drive(1, 0, 0, '0, 0, 0, 0, 1, 2);
        drive(1, 0, 0, '0, 0, 0, 0, 1, 3);
        idle();
        do_reset();
        idle();
        drive(1, 0, 0, '0, 1, 1, 2, 0, 0);
        rand_cycles(300);
        idle();
        idle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rdq_drain", k, W'(rd_q[k].size()), '0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
